// File: rtl/fma16_norm.sv
// Sequential post-add normalizer for the fp16 FMA datapath.
// Left-shifts the sum until bit 33 is set, clamping at the subnormal boundary.
module fma16_norm (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [33:0] Sm,
    input  logic [7:0]  Se,
    input  logic        StickyIn,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [10:0] Rm,
    output logic        G,
    output logic        S,
    output logic [7:0]  Re,
    output logic [5:0]  Lz,
    output logic        Zero,
    output logic        Subnorm
);

    localparam int unsigned SUM_W = 34;
    localparam int unsigned EXP_W = 8;
    localparam int unsigned LZ_W  = 6;
    localparam int unsigned RM_W  = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                   r_state;
    logic                     r_in_ready;
    logic                     r_out_valid;
    logic [SUM_W-1:0]         r_mn;
    logic signed [EXP_W-1:0]  r_wre;
    logic [LZ_W-1:0]          r_wlz;
    logic                     r_sticky;
    logic [RM_W-1:0]          r_rm;
    logic                     r_g;
    logic                     r_s;
    logic [EXP_W-1:0]         r_re;
    logic [LZ_W-1:0]          r_lz;
    logic                     r_zero;
    logic                     r_subnorm;

    logic w_mn_zero;
    logic w_hi8_zero;
    logic w_re_ge9;
    logic w_re_ge2;
    logic w_sticky;

    // Step-selection terms for the current working value
    assign w_mn_zero  = (r_mn == '0);
    assign w_hi8_zero = (r_mn[33:26] == 8'h00);
    assign w_re_ge9   = (r_wre >= 8'sd9);
    assign w_re_ge2   = (r_wre >= 8'sd2);
    assign w_sticky   = (|r_mn[21:0]) | r_sticky;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_mn        <= '0;
            r_wre       <= '0;
            r_wlz       <= '0;
            r_sticky    <= 1'b0;
            r_rm        <= '0;
            r_g         <= 1'b0;
            r_s         <= 1'b0;
            r_re        <= '0;
            r_lz        <= '0;
            r_zero      <= 1'b0;
            r_subnorm   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_mn       <= Sm;
                        r_wre      <= $signed(Se);
                        r_wlz      <= '0;
                        r_sticky   <= StickyIn;
                        r_state    <= ST_SHIFT;
                        r_in_ready <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (w_mn_zero || r_mn[33] || !(w_hi8_zero && w_re_ge9) && !w_re_ge2) begin
                        // Terminal step: publish the rounding fields
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_rm        <= r_mn[33:23];
                        r_g         <= r_mn[22];
                        r_s         <= w_sticky;
                        r_lz        <= r_wlz;
                        r_zero      <= w_mn_zero;
                        r_subnorm   <= !w_mn_zero && !r_mn[33];
                        r_re        <= w_mn_zero ? 8'h00 : EXP_W'(r_wre);
                    end else if (w_hi8_zero && w_re_ge9) begin
                        r_mn  <= {r_mn[25:0], 8'h00};
                        r_wre <= r_wre - 8'sd8;
                        r_wlz <= r_wlz + 6'd8;
                    end else begin
                        r_mn  <= {r_mn[32:0], 1'b0};
                        r_wre <= r_wre - 8'sd1;
                        r_wlz <= r_wlz + 6'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign Rm        = r_rm;
    assign G         = r_g;
    assign S         = r_s;
    assign Re        = r_re;
    assign Lz        = r_lz;
    assign Zero      = r_zero;
    assign Subnorm   = r_subnorm;

endmodule

// File: tb/tb_fma16_norm.sv
// Directed-vector bench for fma16_norm: latency, rounding fields,
// clamp boundaries, back-pressure and mid-operation reset.
module tb_fma16_norm;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [33:0] Sm;
    logic [7:0]  Se;
    logic        StickyIn;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] Rm;
    logic        G;
    logic        S;
    logic [7:0]  Re;
    logic [5:0]  Lz;
    logic        Zero;
    logic        Subnorm;

    int n_checks;
    int n_fail;

    localparam int unsigned BUDGET = 60;

    fma16_norm dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Sm        (Sm),
        .Se        (Se),
        .StickyIn  (StickyIn),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Rm        (Rm),
        .G         (G),
        .S         (S),
        .Re        (Re),
        .Lz        (Lz),
        .Zero      (Zero),
        .Subnorm   (Subnorm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [10:0] rm, input logic g,
                                 input logic s, input logic [7:0] re, input logic [5:0] lz,
                                 input logic zero, input logic sub);
        check({tag, ".Rm"}, 64'(Rm), 64'(rm));
        check({tag, ".G"}, 64'(G), 64'(g));
        check({tag, ".S"}, 64'(S), 64'(s));
        check({tag, ".Re"}, 64'(Re), 64'(re));
        check({tag, ".Lz"}, 64'(Lz), 64'(lz));
        check({tag, ".Zero"}, 64'(Zero), 64'(zero));
        check({tag, ".Subnorm"}, 64'(Subnorm), 64'(sub));
    endtask

    // Present one beat and wait for the accept edge; leaves us #1 after it
    task automatic accept(input string tag, input logic [33:0] sm, input logic [7:0] se,
                          input logic st);
        check({tag, ".in_ready_pre"}, 64'(in_ready), 64'd1);
        Sm       = sm;
        Se       = se;
        StickyIn = st;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check({tag, ".in_ready_busy"}, 64'(in_ready), 64'd0);
    endtask

    task automatic wait_valid(output int lat);
        lat = BUDGET + 1;
        for (int i = 1; i <= BUDGET; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, ".out_valid_post"}, 64'(out_valid), 64'd0);
        check({tag, ".in_ready_post"}, 64'(in_ready), 64'd1);
    endtask

    task automatic run_vec(input string tag, input logic [33:0] sm, input logic [7:0] se,
                           input logic st, input int exp_lat, input logic [10:0] rm,
                           input logic g, input logic s, input logic [7:0] re,
                           input logic [5:0] lz, input logic zero, input logic sub);
        int lat;
        accept(tag, sm, se, st);
        wait_valid(lat);
        check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        check_outputs(tag, rm, g, s, re, lz, zero, sub);
        consume(tag);
    endtask

    initial begin
        int lat;
        n_checks  = 0;
        n_fail    = 0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        Sm        = '0;
        Se        = '0;
        StickyIn  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst.in_ready", 64'(in_ready), 64'd1);
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check_outputs("rst", 11'h000, 1'b0, 1'b0, 8'd0, 6'd0, 1'b0, 1'b0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        //      tag        Sm              Se     St  lat Rm      G     S     Re     Lz     Zero  Sub
        run_vec("norm",   34'h2_0000_0000, 8'd15, 1'b0, 1, 11'h400, 1'b0, 1'b0, 8'd15, 6'd0,  1'b0, 1'b0);
        run_vec("maxsh",  34'h0_0000_0001, 8'd50, 1'b0, 6, 11'h400, 1'b0, 1'b0, 8'd17, 6'd33, 1'b0, 1'b0);
        run_vec("mixed",  34'h0_0080_0000, 8'd20, 1'b1, 4, 11'h400, 1'b0, 1'b1, 8'd10, 6'd10, 1'b0, 1'b0);
        run_vec("clamp",  34'h0_0000_0400, 8'd5,  1'b0, 5, 11'h000, 1'b0, 1'b1, 8'd1,  6'd4,  1'b0, 1'b1);
        run_vec("zero",   34'h0_0000_0000, 8'd20, 1'b1, 1, 11'h000, 1'b0, 1'b1, 8'd0,  6'd0,  1'b1, 1'b0);
        run_vec("guard",  34'h3_FFC0_0001, 8'd7,  1'b0, 1, 11'h7FF, 1'b1, 1'b1, 8'd7,  6'd0,  1'b0, 1'b0);
        run_vec("se0",    34'h1_0000_0000, 8'd0,  1'b0, 1, 11'h200, 1'b0, 1'b0, 8'd0,  6'd0,  1'b0, 1'b1);
        run_vec("seneg",  34'h3_0000_0001, 8'hFD, 1'b0, 1, 11'h600, 1'b0, 1'b1, 8'hFD, 6'd0,  1'b0, 1'b0);
        run_vec("re9",    34'h0_0100_0000, 8'd9,  1'b0, 2, 11'h200, 1'b0, 1'b0, 8'd1,  6'd8,  1'b0, 1'b1);
        run_vec("re8",    34'h0_0100_0000, 8'd8,  1'b0, 8, 11'h100, 1'b0, 1'b0, 8'd1,  6'd7,  1'b0, 1'b1);

        // Back-pressure: results hold and a competing input is refused
        accept("bp", 34'h0_0080_0000, 8'd20, 1'b1);
        wait_valid(lat);
        check("bp.latency", 64'(lat), 64'd4);
        Sm       = 34'h2_0000_0000;
        Se       = 8'd3;
        StickyIn = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("bp.out_valid_hold", 64'(out_valid), 64'd1);
            check("bp.in_ready_hold", 64'(in_ready), 64'd0);
            check_outputs("bp.hold", 11'h400, 1'b0, 1'b1, 8'd10, 6'd10, 1'b0, 1'b0);
        end
        in_valid = 1'b0;
        consume("bp");
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("bp.no_second", 64'(out_valid), 64'd0);
        end

        // Reset mid-SHIFT abandons the beat
        accept("rs", 34'h0_0000_0001, 8'd50, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("rs.in_ready", 64'(in_ready), 64'd1);
        check("rs.out_valid", 64'(out_valid), 64'd0);
        check_outputs("rs", 11'h000, 1'b0, 1'b0, 8'd0, 6'd0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check("rs.no_beat", 64'(out_valid), 64'd0);
        end

        // Block still works after the abandoned operation
        run_vec("post",   34'h0_0080_0000, 8'd20, 1'b0, 4, 11'h400, 1'b0, 1'b0, 8'd10, 6'd10, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
